pipeline_exa_muldiv: RTL and testbench
======================================

Name: pipeline_exa_muldiv

Overview:
- Iterative RV64M multiply/divide unit inside the EXA stage.
- Accepts one M-extension operation from ID/EXA and computes it over multiple cycles.
- Holds the pipeline through `busy` (OR-ed into the global stall) while it computes.
- Presents the result on `result` so the EXA→EXC register captures it on the first un-stalled edge.

Parameters:
- XLEN, 64, operand/result width; the W-variant width is fixed at 32.

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  synchronous, active-high reset
- flush  input  1  pipeline flush; abandons any operation in flight
- start  input  1  M-op present in EXA this cycle
- op  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- op_w  input  1  W variant (MULW/DIVW/DIVUW/REMW/REMUW)
- rs1_data  input  XLEN  operand A
- rs2_data  input  XLEN  operand B
- busy  output  1  stall request to the pipeline
- done  output  1  one-cycle pulse; result valid
- result  output  XLEN  computed value, held until the next accepted start

Behaviour:
- Reset (synchronous, clk edge with reset=1):
  - state=IDLE; result=0; done=0; internal counters and accumulators cleared.
  - Reset mid-operation discards the operation; no done pulse follows.
- States: IDLE, CALC, DONE.
- `busy` (combinational) = (state==IDLE & start & ~flush) | (state==CALC). `busy`=0 in DONE so the pipeline advances.
- IDLE, edge with start=1 & flush=0: latch operands, op, op_w.
  - W ops use the low 32 bits of each operand, sign- or zero-extended per the signedness of op.
  - Signed operands are converted to magnitudes; the result sign is recorded.
  - Special cases go straight to DONE with the result prepared:
    - divisor==0: quotient = all ones; remainder = dividend (width-truncated, then sign-extended for W).
    - signed overflow (DIV/REM, dividend = most-negative, divisor = -1): quotient = most-negative; remainder = 0.
    - illegal combination (op_w=1 with op 001/010/011): result = 0.
  - Otherwise go to CALC with iteration count N = XLEN (64), or 32 when op_w=1.
- CALC:
  - Multiply: one shift-add step per cycle, building a 2·XLEN product.
  - Divide: one restoring-division step per cycle, producing quotient and remainder.
  - After exactly N CALC edges, apply sign correction and go to DONE.
  - Result selection:
    - MUL: low XLEN bits.
    - MULH/MULHSU/MULHU: high XLEN bits. MULHSU treats rs1 as signed and rs2 as unsigned.
    - Quotient/remainder sign rules follow RV64M: the remainder takes the dividend's sign.
    - W results are the low 32 bits sign-extended to 64, for all W ops including DIVUW/REMUW.
- DONE: done=1 and `result` valid for this cycle; next edge goes to IDLE.
  - `result` register holds its value after DONE until the next accepted start.
- Latency:
  - Normal ops: start edge → done visible N+1 cycles later (65 for 64-bit, 33 for W).
  - Special cases: done visible 1 cycle after the start edge.
- start while in CALC/DONE is ignored; the upstream stage keeps start asserted only while stalled.
- flush=1: any state → IDLE on the next edge; done=0; result unchanged. flush wins over start in the same cycle.
- reset has priority over flush and start.

Test Plan:
- MUL, rs1=7, rs2=-3 (0xFFFF_FFFF_FFFF_FFFD) → busy high 65 cycles (start cycle through last CALC); done pulse 65 cycles after start edge; result=0xFFFF_FFFF_FFFF_FFEB (-21).
- MULHU, rs1=rs2=0xFFFF_FFFF_FFFF_FFFF → result=0xFFFF_FFFF_FFFF_FFFE. Same operands with MULH → result=0; with MULHSU → result=0xFFFF_FFFF_FFFF_FFFF.
- DIV, rs1=-7, rs2=2 → result=-3. REM, same operands → result=-1. DIVU, rs1=100, rs2=7 → result=14, done after 65 cycles.
- Special cases (done after 1 cycle, busy high 1 cycle):
  - DIV by 0 → result=0xFFFF_FFFF_FFFF_FFFF.
  - REMU, rs1=0x1234, rs2=0 → result=0x1234.
  - DIV, rs1=0x8000_0000_0000_0000, rs2=-1 → result=0x8000_0000_0000_0000.
  - REM with the same operands → result=0.
- DIVUW, rs1=0xFFFF_FFFF_8000_0000, rs2=1 → 33-cycle latency; result=0xFFFF_FFFF_8000_0000 (sign-extended). MULW, rs1=0x7FFF_FFFF, rs2=2 → result=0xFFFF_FFFF_FFFF_FFFE.
- Interruptions and back-to-back:
  - flush asserted 10 cycles into a DIV → IDLE next edge; no done pulse; busy=0.
  - reset asserted mid-MUL → result=0, done=0, IDLE.
  - Back-to-back MUL then DIV → second start accepted the cycle after DONE; both results correct.

Source files
------------

// File: rtl/pipeline_exa_muldiv.sv
// Iterative RV64M multiply/divide unit for the EXA stage: one shift-add or
// restoring-division step per cycle, stalling the pipeline through busy.
module pipeline_exa_muldiv #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic            op_w,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned WLEN = 32;
  localparam int unsigned CntW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e              state_q, state_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     b_q, b_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [2:0]          op_q, op_d;
  logic                op_w_q, op_w_d;
  logic                neg_q, neg_d;
  logic [XLEN-1:0]     result_q, result_d;

  // Operand preparation at accept time
  logic            is_div, sgn_a, sgn_b, a_neg, b_neg, div0, ovf, illegal, neg_start;
  logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, a_w_sx, most_neg;

  assign is_div = op[2];
  assign sgn_a  = op[2] ? ~op[0] : (op[1:0] != 2'b11);
  assign sgn_b  = op[2] ? ~op[0] : ~op[1];
  assign a_ext  = op_w ? {{(XLEN-WLEN){sgn_a & rs1_data[WLEN-1]}}, rs1_data[WLEN-1:0]}
                       : rs1_data;
  assign b_ext  = op_w ? {{(XLEN-WLEN){sgn_b & rs2_data[WLEN-1]}}, rs2_data[WLEN-1:0]}
                       : rs2_data;
  assign a_w_sx = {{(XLEN-WLEN){rs1_data[WLEN-1]}}, rs1_data[WLEN-1:0]};
  assign a_neg  = sgn_a & a_ext[XLEN-1];
  assign b_neg  = sgn_b & b_ext[XLEN-1];
  assign a_mag  = a_neg ? -a_ext : a_ext;
  assign b_mag  = b_neg ? -b_ext : b_ext;
  // Remainder follows the dividend sign; everything else is the sign product
  assign neg_start = (is_div & op[1]) ? a_neg : (a_neg ^ b_neg);

  assign most_neg = op_w ? {{(XLEN-WLEN+1){1'b1}}, {(WLEN-1){1'b0}}}
                         : {1'b1, {(XLEN-1){1'b0}}};
  assign div0     = is_div & (b_ext == '0);
  assign ovf      = is_div & ~op[0] & (a_ext == most_neg) & (b_ext == '1);
  assign illegal  = op_w & ~op[2] & (op[1:0] != 2'b00);

  // One iteration step; acc holds {hi, lo} for both multiply and divide
  logic [XLEN:0]     mul_sum, div_r, div_diff;
  logic              div_ge;
  logic [2*XLEN-1:0] step_acc;

  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
  assign div_r    = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
  assign div_diff = div_r - {1'b0, b_q};
  assign div_ge   = ~div_diff[XLEN];
  assign step_acc = op_q[2]
                  ? {(div_ge ? div_diff[XLEN-1:0] : div_r[XLEN-1:0]), acc_q[XLEN-2:0], div_ge}
                  : {mul_sum, acc_q[XLEN-1:1]};

  // Result formation from the final step
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   dv, dv_s, full, final_res;

  // A W multiply leaves its 64-bit product shifted up by 32 after 32 steps
  assign prod   = op_w_q ? {{XLEN{1'b0}}, step_acc[XLEN+WLEN-1:WLEN]} : step_acc;
  assign prod_s = neg_q ? -prod : prod;
  assign dv     = op_q[1] ? step_acc[2*XLEN-1:XLEN] : step_acc[XLEN-1:0];
  assign dv_s   = neg_q ? -dv : dv;
  assign full   = op_q[2] ? dv_s
                : ((op_q[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN]);
  assign final_res = op_w_q ? {{(XLEN-WLEN){full[WLEN-1]}}, full[WLEN-1:0]} : full;

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    op_w_d   = op_w_q;
    neg_d    = neg_q;
    result_d = result_q;
    if (flush) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            op_d   = op;
            op_w_d = op_w;
            neg_d  = neg_start;
            cnt_d  = op_w ? CntW'(WLEN) : CntW'(XLEN);
            if (is_div) begin
              b_d   = b_mag;
              acc_d = {{XLEN{1'b0}},
                       (op_w ? {a_mag[WLEN-1:0], {(XLEN-WLEN){1'b0}}} : a_mag)};
            end else begin
              b_d   = a_mag;
              acc_d = {{XLEN{1'b0}}, b_mag};
            end
            if (illegal) begin
              result_d = '0;
              state_d  = StDone;
            end else if (div0) begin
              result_d = op[1] ? (op_w ? a_w_sx : rs1_data) : '1;
              state_d  = StDone;
            end else if (ovf) begin
              result_d = op[1] ? '0 : a_ext;
              state_d  = StDone;
            end else begin
              state_d = StCalc;
            end
          end
        end
        StCalc: begin
          acc_d = step_acc;
          cnt_d = cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) begin
            result_d = final_res;
            state_d  = StDone;
          end
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      acc_q    <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      op_q     <= '0;
      op_w_q   <= 1'b0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      op_w_q   <= op_w_d;
      neg_q    <= neg_d;
      result_q <= result_d;
    end
  end

  assign busy   = ((state_q == StIdle) & start & ~flush) | (state_q == StCalc);
  assign done   = (state_q == StDone);
  assign result = result_q;

endmodule

// File: tb/tb_pipeline_exa_muldiv.sv
// Directed bench for pipeline_exa_muldiv: latency, busy window, results,
// special cases, flush, reset and back-to-back issue.
module tb_pipeline_exa_muldiv;

  logic        clk = 1'b0;
  logic        reset, flush, start, op_w;
  logic [2:0]  op;
  logic [63:0] rs1_data, rs2_data, result;
  logic        busy, done;

  int checks   = 0;
  int failures = 0;

  pipeline_exa_muldiv #(.XLEN(64)) dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .start    (start),
    .op       (op),
    .op_w     (op_w),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  always #5 clk = ~clk;

  task automatic chk64(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic chkint(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge of the cycle after DONE
  task automatic run_op(input string tag, input logic [2:0] o, input logic w,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp, input int exp_lat);
    int lat;
    int busy_cnt;
    start = 1'b1; op = o; op_w = w; rs1_data = a; rs2_data = b;
    #1;
    chk1({tag, "_busy_start"}, busy, 1'b1);
    busy_cnt = 1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 200) begin
      busy_cnt += busy;
      @(negedge clk);
      lat++;
    end
    chk1({tag, "_done"}, done, 1'b1);
    chkint({tag, "_lat"}, lat, exp_lat);
    chkint({tag, "_busy_cycles"}, busy_cnt, exp_lat);
    chk1({tag, "_busy_in_done"}, busy, 1'b0);
    chk64({tag, "_result"}, result, exp);
    @(negedge clk);
    chk1({tag, "_done_pulse"}, done, 1'b0);
    chk64({tag, "_result_held"}, result, exp);
  endtask

  initial begin
    int seen;
    reset = 1'b1; flush = 1'b0; start = 1'b0; op = 3'b000; op_w = 1'b0;
    rs1_data = '0; rs2_data = '0;
    repeat (3) @(negedge clk);
    chk64("reset_result", result, 64'h0);
    chk1("reset_done", done, 1'b0);
    chk1("reset_busy", busy, 1'b0);
    reset = 1'b0;
    @(negedge clk);

    run_op("mul",    3'b000, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65);
    run_op("mulhu",  3'b011, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 65);
    run_op("mulh",   3'b001, 1'b0, '1, '1, 64'h0, 65);
    run_op("mulhsu", 3'b010, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFF, 65);
    run_op("div",    3'b100, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65);
    run_op("rem",    3'b110, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65);
    run_op("divu",   3'b101, 1'b0, 64'd100, 64'd7, 64'd14, 65);
    run_op("div0",   3'b100, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    run_op("remu0",  3'b111, 1'b0, 64'h1234, 64'd0, 64'h1234, 1);
    run_op("div_ovf", 3'b100, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1);
    run_op("rem_ovf", 3'b110, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h0, 1);
    run_op("divuw",  3'b101, 1'b1, 64'hFFFF_FFFF_8000_0000, 64'd1, 64'hFFFF_FFFF_8000_0000, 33);
    run_op("mulw",   3'b000, 1'b1, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 33);
    run_op("mulhw_illegal", 3'b001, 1'b1, 64'd3, 64'd5, 64'h0, 1);
    run_op("remw0",  3'b110, 1'b1, 64'h0000_0001_8000_0001, 64'h1_0000_0000,
           64'hFFFF_FFFF_8000_0001, 1);

    // Flush 10 cycles into a DIV: no done, result unchanged
    start = 1'b1; op = 3'b100; op_w = 1'b0; rs1_data = 64'd100; rs2_data = 64'd7;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk1("flush_busy", busy, 1'b0);
    chk1("flush_done", done, 1'b0);
    seen = 0;
    repeat (70) begin
      @(negedge clk);
      if (done) seen++;
    end
    chkint("flush_no_done", seen, 0);
    chk64("flush_result_kept", result, 64'hFFFF_FFFF_8000_0001);

    // Flush beats start in the same cycle
    start = 1'b1; flush = 1'b1;
    #1;
    chk1("flush_start_busy", busy, 1'b0);
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    #1;
    chk1("flush_start_idle", busy, 1'b0);
    @(negedge clk);

    // Reset mid-MUL
    start = 1'b1; op = 3'b000; op_w = 1'b0; rs1_data = 64'd9; rs2_data = 64'd9;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk64("rst_mid_result", result, 64'h0);
    chk1("rst_mid_done", done, 1'b0);
    chk1("rst_mid_busy", busy, 1'b0);
    seen = 0;
    repeat (70) begin
      @(negedge clk);
      if (done) seen++;
    end
    chkint("rst_mid_no_done", seen, 0);

    // Back-to-back: second start issued in the cycle right after DONE
    run_op("b2b_mul", 3'b000, 1'b0, 64'd6, 64'd7, 64'd42, 65);
    run_op("b2b_div", 3'b100, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd9, 64'hFFFF_FFFF_FFFF_FFF5, 65);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
